// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file widths and the hard-wired zero register index
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/reg_file.sv
// reg_file: two read ports plus debug read, x0 hard-wired to zero, optional write bypass, saturating write counter
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       dbg_data,
  output logic [15:0]           wr_count
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] regs [NREG];
  logic wen;
  logic [REG_ADDR_W-1:0] raddr [3];
  logic [XLEN-1:0] rdata [3];
  assign wen = reg_write && rd_addr != ZERO_REG && int'(rd_addr) < NREG;
  // storage: x0 slot is never written so it stays zero after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (wen)
      regs[rd_addr[AW-1:0]] <= rd_data;
  // committed-write counter, holds at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      wr_count <= '0;
    else if (wen && wr_count != 16'hFFFF)
      wr_count <= wr_count + 16'd1;
  assign raddr[0] = rs1_addr;
  assign raddr[1] = rs2_addr;
  assign raddr[2] = dbg_addr;
  // one read-select path per port; the debug port (index 2) never forwards
  for (genvar g = 0; g < 3; g++) begin : g_rd
    logic hit;
    assign hit = BYPASS && g != 2 && wen && raddr[g] == rd_addr;
    assign rdata[g] = (!rst_n || raddr[g] == ZERO_REG || int'(raddr[g]) >= NREG) ? '0 :
                      hit ? rd_data : regs[raddr[g][AW-1:0]];
  end
  assign rs1_data = rdata[0];
  assign rs2_data = rdata[1];
  assign dbg_data = rdata[2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file with bypass on and off instances
module tb_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0, dbg_addr = '0;
  logic reg_write = 1'b0;
  logic [31:0] rd_data = '0;
  logic [31:0] rs1_b, rs2_b, dbg_b, rs1_n, rs2_n, dbg_n;
  logic [15:0] cnt_b, cnt_n;
  typedef struct {
    int port;
    logic [31:0] exp;
    string tag;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] mregs [32];
  logic [15:0] mcnt = '0;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_b), .rs2_data(rs2_b), .reg_write(reg_write), .rd_addr(rd_addr),
    .rd_data(rd_data), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_count(cnt_b)
  );
  reg_file #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_n), .rs2_data(rs2_n), .reg_write(reg_write), .rd_addr(rd_addr),
    .rd_data(rd_data), .dbg_addr(dbg_addr), .dbg_data(dbg_n), .wr_count(cnt_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int port);
    case (port)
      0: return rs1_b;
      1: return rs2_b;
      2: return dbg_b;
      3: return {16'h0, cnt_b};
      4: return rs1_n;
      5: return rs2_n;
      6: return dbg_n;
      default: return {16'h0, cnt_n};
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return '0;
    if (byp && reg_write && rd_addr != 5'd0 && a == rd_addr) return rd_data;
    return mregs[a];
  endfunction

  task automatic drain;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, obs(e.port), e.exp);
    end
  endtask

  task automatic step(input bit we, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                      input string tag);
    reg_write = we;
    rd_addr = rd;
    rd_data = wd;
    rs1_addr = a1;
    rs2_addr = a2;
    dbg_addr = ad;
    #1;
    sb.push_back('{0, mread(a1, 1'b1), {tag, ".rs1_byp"}});
    sb.push_back('{1, mread(a2, 1'b1), {tag, ".rs2_byp"}});
    sb.push_back('{2, mread(ad, 1'b0), {tag, ".dbg_byp"}});
    sb.push_back('{3, {16'h0, mcnt}, {tag, ".cnt_byp"}});
    sb.push_back('{4, mread(a1, 1'b0), {tag, ".rs1_nobyp"}});
    sb.push_back('{5, mread(a2, 1'b0), {tag, ".rs2_nobyp"}});
    sb.push_back('{6, mread(ad, 1'b0), {tag, ".dbg_nobyp"}});
    sb.push_back('{7, {16'h0, mcnt}, {tag, ".cnt_nobyp"}});
    drain();
    @(posedge clk);
    if (rst_n && we && rd != 5'd0) begin
      mregs[rd] = wd;
      if (mcnt != 16'hFFFF) mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcnt = '0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    step(1'b1, 5'd5, 32'h11112222, 5'd5, 5'd5, 5'd5, "in_reset_write");
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) step(1'b0, 5'd0, '0, 5'(a), 5'(31 - a), 5'(a), $sformatf("reset_read%0d", a));
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 5'd5, "wr_x5");
    step(1'b0, 5'd0, '0, 5'd5, 5'd5, 5'd5, "rd_x5");
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, "wr_x0");
    step(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, "rd_x0");
    step(1'b1, 5'd7, 32'h11111111, 5'd1, 5'd2, 5'd3, "wr_x7_old");
    step(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7, "bypass_x7");
    step(1'b0, 5'd0, '0, 5'd7, 5'd5, 5'd7, "rd_x7");
    step(1'b1, 5'd9, 32'hAAAA0001, 5'd9, 5'd0, 5'd9, "b2b_a");
    step(1'b1, 5'd9, 32'hAAAA0002, 5'd9, 5'd9, 5'd9, "b2b_b");
    step(1'b1, 5'd31, 32'h0F0F0F0F, 5'd9, 5'd31, 5'd31, "b2b_read");
    step(1'b0, 5'd0, '0, 5'd31, 5'd9, 5'd9, "rd_x31");
    step(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd4, 5'd3, "wr_x3");
    rst_n = 1'b0;
    model_reset();
    step(1'b1, 5'd4, 32'h44444444, 5'd3, 5'd4, 5'd3, "mid_reset");
    rst_n = 1'b1;
    step(1'b1, 5'd4, 32'h55555555, 5'd3, 5'd4, 5'd4, "first_after_reset");
    step(1'b0, 5'd0, '0, 5'd4, 5'd3, 5'd4, "rd_x4");
    reg_write = 1'b1;
    rd_addr = 5'd1;
    rd_data = 32'hCAFE0001;
    repeat (65537) @(posedge clk);
    @(negedge clk);
    mregs[1] = 32'hCAFE0001;
    mcnt = 16'hFFFF;
    step(1'b1, 5'd2, 32'h22222222, 5'd1, 5'd2, 5'd1, "sat");
    step(1'b0, 5'd0, '0, 5'd2, 5'd1, 5'd2, "sat_hold");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
